// File: rtl/spi_master.sv
// spi_master: mode-0 (CPOL=0, CPHA=0) SPI initiator, one width-bit full-duplex
// transfer per accepted start, MSB first. sclk runs at clk/(2*CLK_DIV).
// Optional build macro SPI_MASTER_LOOPBACK_EN: the receive path samples the
// internal mosi instead of the miso port (miso is then ignored).
// width must be at least 2.
module spi_master #(
  parameter int width   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] txData,
  input  logic             keepCs,
  output logic [width-1:0] rxData,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(width + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(width);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH} stateType;

  stateType         stateReg, stateNext;
  logic [DW-1:0]    divCntReg, divCntNext;
  logic [BW-1:0]    bitCntReg, bitCntNext;
  logic [width-1:0] txShiftReg, txShiftNext;
  logic [width-1:0] rxShiftReg, rxShiftNext;
  logic [width-1:0] rxDataReg, rxDataNext;
  logic             keepCsReg, keepCsNext;
  logic             busyReg, busyNext;
  logic             doneReg, doneNext;
  logic             sclkReg, sclkNext;
  logic             csReg, csNext;
  logic             mosiReg, mosiNext;
  logic             divTc;
  logic             rxBit;

  // Receive source: loopback samples what we are driving, so rx mirrors tx.
`ifdef SPI_MASTER_LOOPBACK_EN
  assign rxBit = mosiReg;
`else
  assign rxBit = miso;
`endif

  // Every non-idle state lasts exactly one divider period.
  assign divTc = (divCntReg == DIV_LAST);

  // Register all state and outputs; outputs are glitch-free flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      divCntReg  <= '0;
      bitCntReg  <= '0;
      txShiftReg <= '0;
      rxShiftReg <= '0;
      rxDataReg  <= '0;
      keepCsReg  <= 1'b0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      sclkReg    <= 1'b0;
      csReg      <= 1'b1;
      mosiReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      divCntReg  <= divCntNext;
      bitCntReg  <= bitCntNext;
      txShiftReg <= txShiftNext;
      rxShiftReg <= rxShiftNext;
      rxDataReg  <= rxDataNext;
      keepCsReg  <= keepCsNext;
      busyReg    <= busyNext;
      doneReg    <= doneNext;
      sclkReg    <= sclkNext;
      csReg      <= csNext;
      mosiReg    <= mosiNext;
    end
  end

  // Next-state and next-output logic; each state acts on the divider terminal count.
  always_comb begin
    stateNext   = stateReg;
    divCntNext  = (stateReg == IDLE || divTc) ? '0 : divCntReg + 1'b1;
    bitCntNext  = bitCntReg;
    txShiftNext = txShiftReg;
    rxShiftNext = rxShiftReg;
    rxDataNext  = rxDataReg;
    keepCsNext  = keepCsReg;
    busyNext    = busyReg;
    doneNext    = 1'b0;
    sclkNext    = sclkReg;
    csNext      = csReg;
    mosiNext    = mosiReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          txShiftNext = txData;
          keepCsNext  = keepCs;
          csNext      = 1'b0;
          mosiNext    = txData[width-1];
          busyNext    = 1'b1;
          bitCntNext  = '0;
          stateNext   = SETUP;
        end
      end
      // SETUP gives the first bit a full half-period before the first rising sclk.
      SETUP, LOW: begin
        if (divTc) begin
          sclkNext    = 1'b1;
          rxShiftNext = {rxShiftReg[width-2:0], rxBit};
          bitCntNext  = bitCntReg + 1'b1;
          stateNext   = HIGH;
        end
      end
      HIGH: begin
        if (divTc) begin
          sclkNext = 1'b0;
          if (bitCntReg == BITS_LAST) begin
            stateNext = FINISH;
          end else begin
            txShiftNext = txShiftReg << 1;
            mosiNext    = txShiftReg[width-2];
            stateNext   = LOW;
          end
        end
      end
      // FINISH provides hold time after the last falling sclk before cs releases.
      FINISH: begin
        if (divTc) begin
          rxDataNext = rxShiftReg;
          doneNext   = 1'b1;
          busyNext   = 1'b0;
          csNext     = ~keepCsReg;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign rxData = rxDataReg;
  assign busy   = busyReg;
  assign done   = doneReg;
  assign sclk   = sclkReg;
  assign cs     = csReg;
  assign mosi   = mosiReg;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master (width=8, CLK_DIV=4) with a
// mode-0 peripheral model that shifts out pw and captures mosi words.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] txData;
  logic       keepCs;
  logic [7:0] rxData;
  logic       busy, done, sclk, cs, mosi;
  logic       miso;

  spi_master #(.width(8), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .txData(txData), .keepCs(keepCs),
    .rxData(rxData), .busy(busy), .done(done), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Peripheral model: drives miso on falling sclk, captures mosi on rising sclk.
  logic [7:0] pw = 8'h00;
  logic [2:0] pOut = 3'd0;
  logic [2:0] pBits = 3'd0;
  logic [7:0] pCap = 8'h00;
  logic [7:0] capQ[$];

  assign miso = pw[3'd7 - pOut];

  always @(negedge sclk or posedge cs) begin
    if (cs) pOut = 3'd0;
    else    pOut = pOut + 3'd1;
  end

  always @(posedge sclk or posedge cs) begin
    if (cs) begin
      pBits = 3'd0;
    end else begin
      pCap = {pCap[6:0], mosi};
      if (pBits == 3'd7) begin
        capQ.push_back(pCap);
        pBits = 3'd0;
      end else begin
        pBits = pBits + 3'd1;
      end
    end
  end

  int nChecks = 0;
  int nFails = 0;
  int doneCount = 0;
  int csHighBusy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected received word: peripheral data, or our own tx word in loopback.
  function automatic logic [7:0] expRx(input logic [7:0] tx, input logic [7:0] per);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return per;
`endif
  endfunction

  // One clock: sample #1 after the edge, keep running monitors.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) doneCount++;
    if (busy === 1'b1 && cs !== 1'b0) csHighBusy++;
  endtask

  // Counts cycles until done is seen, bounded.
  task automatic waitDone(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 300);
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Presents start for one edge; that edge is the accepting edge E0.
  task automatic startXfer(input logic [7:0] tx, input logic keep);
    start = 1'b1; txData = tx; keepCs = keep;
    tick();
    start = 1'b0; txData = 8'h00; keepCs = 1'b0;
  endtask

  function automatic logic [7:0] capAt(input int i);
    return (capQ.size() > i) ? capQ[i] : 8'hxx;
  endfunction

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; txData = 8'h00; keepCs = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rxData, 0);

    // Basic transfer A5 against peripheral 3C, 68-cycle latency.
    pw = 8'h3C; capQ.delete();
    startXfer(8'hA5, 1'b0);
    check("acc_busy", busy, 1);
    check("acc_cs", cs, 0);
    check("acc_mosi", mosi, 1);
    waitDone(n);
    $display("xfer tx=a5 rx=%02h cycles=%0d", rxData, n);
    check("a5_latency", n, 68);
    check("a5_rx", rxData, expRx(8'hA5, 8'h3C));
    check("a5_busy", busy, 0);
    check("a5_cs", cs, 1);
    check("a5_cap_n", capQ.size(), 1);
    check("a5_cap", capAt(0), 8'hA5);
    tick();
    check("a5_done_pulse", done, 0);
    check("a5_mosi_hold", mosi, 1);
    check("a5_rx_hold", rxData, expRx(8'hA5, 8'h3C));

    // Reset held two cycles in the middle of a transfer aborts it.
    startXfer(8'hF0, 1'b0);
    repeat (30) tick();
    reset = 1'b1;
    tick(); tick();
    $display("xfer tx=f0 aborted by reset");
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rx", rxData, 0);
    reset = 1'b0;
    tick();

    // start while busy is ignored; exactly one done.
    pw = 8'h96; capQ.delete(); doneCount = 0;
    startXfer(8'h81, 1'b0);
    repeat (20) tick();
    start = 1'b1; txData = 8'hFF;
    tick();
    start = 1'b0; txData = 8'h00;
    waitDone(n);
    $display("xfer tx=81 rx=%02h cycles=%0d", rxData, n + 21);
    check("busy_ign_latency", n + 21, 68);
    check("busy_ign_rx", rxData, expRx(8'h81, 8'h96));
    repeat (80) tick();
    check("busy_ign_dones", doneCount, 1);
    check("busy_ign_cap_n", capQ.size(), 1);
    check("busy_ign_cap", capAt(0), 8'h81);

    // Chained keepCs=1 then keepCs=0: cs low across both words.
    pw = 8'h5A; capQ.delete(); csHighBusy = 0;
    startXfer(8'h12, 1'b1);
    waitDone(n);
    $display("xfer tx=12 rx=%02h cycles=%0d keep=1", rxData, n);
    check("chain1_rx", rxData, expRx(8'h12, 8'h5A));
    check("chain1_cs_kept", cs, 0);
    startXfer(8'h34, 1'b0);
    check("chain2_cs", cs, 0);
    waitDone(n);
    $display("xfer tx=34 rx=%02h cycles=%0d keep=0", rxData, n);
    check("chain2_latency", n, 68);
    check("chain2_rx", rxData, expRx(8'h34, 8'h5A));
    check("chain2_cs_release", cs, 1);
    check("chain_cs_glitch", csHighBusy, 0);
    check("chain_cap_n", capQ.size(), 2);
    check("chain_cap0", capAt(0), 8'h12);
    check("chain_cap1", capAt(1), 8'h34);
    tick();

    // start held high, keepCs=0: back-to-back words, cs high one cycle between.
    pw = 8'hA5; capQ.delete(); doneCount = 0;
    start = 1'b1; txData = 8'h3C; keepCs = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      waitDone(n);
      $display("xfer tx=3c rx=%02h cycles=%0d seq=%0d", rxData, n, k);
      check($sformatf("b2b%0d_latency", k), n, 68);
      check($sformatf("b2b%0d_rx", k), rxData, expRx(8'h3C, 8'hA5));
      check($sformatf("b2b%0d_cs_high", k), cs, 1);
      if (k == 2) start = 1'b0;
      tick();
      check($sformatf("b2b%0d_cs_next", k), cs, (k < 2) ? 32'd0 : 32'd1);
    end
    repeat (10) tick();
    check("b2b_idle", busy, 0);
    check("b2b_dones", doneCount, 3);
    check("b2b_cap_n", capQ.size(), 3);
    check("b2b_cap2", capAt(2), 8'h3C);
    txData = 8'h00;

    // Receive path source check (loopback build returns the tx word).
    pw = 8'h00; capQ.delete();
    startXfer(8'hC3, 1'b0);
    waitDone(n);
    $display("xfer tx=c3 rx=%02h cycles=%0d", rxData, n);
    check("c3_rx", rxData, expRx(8'hC3, 8'h00));
    check("c3_cap", capAt(0), 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
